// File: rtl/front_panel_pkg.sv
// Shared constants and helpers for the front-panel button/counter path.
package front_panel_pkg;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_CLEAR = 2;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width++;
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/debounced_updown_counter_btn.sv
// One button channel: two-FF synchroniser, stable-count debouncer,
// rising-edge press pulse and optional hold-to-repeat pulses.
module btn_debounce_pulse
    import front_panel_pkg::*;
#(
    parameter int DB_CYCLES    = 250000,
    parameter int REPEAT_DELAY = 0,
    parameter int REPEAT_RATE  = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic level,
    output logic pulse
);

    localparam int STABLE_W = clog2(DB_CYCLES + 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(DB_CYCLES - 1);

    logic                sync1_reg;
    logic                sync2_reg;
    logic [STABLE_W-1:0] stable_reg;
    logic                level_reg;
    logic                level_d_reg;
    logic                pulse_reg;
    logic                repeat_hit;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            stable_reg  <= '0;
            level_reg   <= 1'b0;
            level_d_reg <= 1'b0;
            pulse_reg   <= 1'b0;
        end else begin
            sync1_reg <= button;
            sync2_reg <= sync1_reg;
            // Level only flips after DB_CYCLES consecutive disagreeing samples.
            if (sync2_reg == level_reg) begin
                stable_reg <= '0;
            end else if (stable_reg == STABLE_LAST) begin
                stable_reg <= '0;
                level_reg  <= ~level_reg;
            end else begin
                stable_reg <= stable_reg + STABLE_W'(1);
            end
            level_d_reg <= level_reg;
            pulse_reg   <= (level_reg & ~level_d_reg) | repeat_hit;
        end
    end

    generate
        if (REPEAT_DELAY > 0) begin : g_repeat
            localparam int HOLD_W = clog2(REPEAT_DELAY + REPEAT_RATE + 1);
            logic [HOLD_W-1:0] hold_reg;
            logic [HOLD_W-1:0] hold_next;

            // After the first repeat the counter cycles DELAY..DELAY+RATE-1,
            // so every return to DELAY marks one more repeat.
            always_comb begin
                hold_next = hold_reg + HOLD_W'(1);
                if (hold_next == HOLD_W'(REPEAT_DELAY + REPEAT_RATE)) begin
                    hold_next = HOLD_W'(REPEAT_DELAY);
                end
            end

            always_ff @(posedge clock) begin
                if (reset || !level_reg) begin
                    hold_reg <= '0;
                end else begin
                    hold_reg <= hold_next;
                end
            end

            assign repeat_hit = level_reg && (hold_next == HOLD_W'(REPEAT_DELAY));
        end else begin : g_no_repeat
            assign repeat_hit = 1'b0;
        end
    endgenerate

    assign level = level_reg;
    assign pulse = pulse_reg;

endmodule

// File: rtl/debounced_updown_counter.sv
// Up/down/clear front-panel counter: three debounced buttons step an
// N-bit count that wraps or saturates and drives the LED bank.
module debounced_updown_counter
    import front_panel_pkg::*;
#(
    parameter int N            = 6,
    parameter int DB_CYCLES    = 250000,
    parameter int REPEAT_DELAY = 0,
    parameter int REPEAT_RATE  = 50000,
    parameter int SATURATE     = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [2:0]   buttons,
    output logic [N-1:0] leds,
    output logic [2:0]   pressed,
    output logic         at_max,
    output logic         at_min
);

    localparam logic [N-1:0] COUNT_MAX = '1;

    logic [2:0]   level_vec;
    logic [2:0]   pulse_vec;
    logic [N-1:0] count_reg;
    logic [N-1:0] count_next;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            btn_debounce_pulse #(
                .DB_CYCLES   (DB_CYCLES),
                .REPEAT_DELAY((gi == BTN_CLEAR) ? 0 : REPEAT_DELAY),
                .REPEAT_RATE (REPEAT_RATE)
            ) u_btn (
                .clock (clock),
                .reset (reset),
                .button(buttons[gi]),
                .level (level_vec[gi]),
                .pulse (pulse_vec[gi])
            );
        end
    endgenerate

    // Clear wins; up and down together cancel.
    always_comb begin
        count_next = count_reg;
        if (pulse_vec[BTN_CLEAR]) begin
            count_next = '0;
        end else if (pulse_vec[BTN_UP] && !pulse_vec[BTN_DOWN]) begin
            if (count_reg != COUNT_MAX || SATURATE == MODE_WRAP) begin
                count_next = count_reg + N'(1);
            end
        end else if (pulse_vec[BTN_DOWN] && !pulse_vec[BTN_UP]) begin
            if (count_reg != '0 || SATURATE == MODE_WRAP) begin
                count_next = count_reg - N'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign leds    = count_reg;
    assign pressed = level_vec;
    assign at_max  = (count_reg == COUNT_MAX);
    assign at_min  = (count_reg == '0);

endmodule

// File: tb/tb_debounced_updown_counter.sv
// Drives a wrapping and a saturating counter with the same button stimulus
// and checks latency, debounce, auto-repeat, priority and reset behaviour.
module tb_debounced_updown_counter;
    import front_panel_pkg::*;

    localparam int N  = 4;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic         clock = 1'b0;
    logic         reset;
    logic [2:0]   buttons;
    logic [N-1:0] leds, leds_sat;
    logic [2:0]   pressed, pressed_sat;
    logic         at_max, at_min, at_max_sat, at_min_sat;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    debounced_updown_counter #(
        .N(N), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .SATURATE(MODE_WRAP)
    ) dut (
        .clock(clock), .reset(reset), .buttons(buttons), .leds(leds),
        .pressed(pressed), .at_max(at_max), .at_min(at_min)
    );

    debounced_updown_counter #(
        .N(N), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .SATURATE(MODE_SAT)
    ) dut_sat (
        .clock(clock), .reset(reset), .buttons(buttons), .leds(leds_sat),
        .pressed(pressed_sat), .at_max(at_max_sat), .at_min(at_min_sat)
    );

    typedef struct {
        logic [2:0] btn;
        int         hold;
        int         exp_wrap;
        int         exp_sat;
    } step_t;

    typedef struct {
        int idx;
        int exp_wrap;
        int exp_sat;
    } sb_t;

    step_t steps[15];
    sb_t   sb_q[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check_state(input string name, input int exp_wrap, input int exp_sat);
        check({name, " leds"},        32'(leds),        32'(exp_wrap));
        check({name, " at_max"},      32'(at_max),      32'(exp_wrap == 15));
        check({name, " at_min"},      32'(at_min),      32'(exp_wrap == 0));
        check({name, " pressed"},     32'(pressed),     32'd0);
        check({name, " sat leds"},    32'(leds_sat),    32'(exp_sat));
        check({name, " sat at_max"},  32'(at_max_sat),  32'(exp_sat == 15));
        check({name, " sat at_min"},  32'(at_min_sat),  32'(exp_sat == 0));
        check({name, " sat pressed"}, 32'(pressed_sat), 32'd0);
    endtask

    task automatic press(input logic [2:0] btn, input int hold);
        buttons = btn;
        repeat (hold) tick();
        buttons = 3'b000;
        repeat (14) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        steps[0]  = '{3'b010, 5,  0,  0};
        steps[1]  = '{3'b010, 5, 15,  0};
        steps[2]  = '{3'b001, 5,  0,  1};
        steps[3]  = '{3'b100, 5,  0,  0};
        steps[4]  = '{3'b011, 5,  0,  0};
        steps[5]  = '{3'b001, 5,  1,  1};
        steps[6]  = '{3'b101, 5,  0,  0};
        steps[7]  = '{3'b010, 5, 15,  0};
        steps[8]  = '{3'b100, 5,  0,  0};
        steps[9]  = '{3'b001, 30, 8,  8};
        steps[10] = '{3'b100, 5,  0,  0};
        steps[11] = '{3'b001, 30, 8,  8};
        steps[12] = '{3'b001, 30, 0, 15};
        steps[13] = '{3'b001, 5,  1, 15};
        steps[14] = '{3'b010, 5,  0, 14};

        buttons = 3'b000;
        reset   = 1'b1;
        repeat (3) tick();
        check_state("reset", 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_state("idle", 0, 0);
        end
        $display("idle after reset: leds=%0d pressed=%b", leds, pressed);

        // Press latency, counted from the edge that first samples the new level.
        buttons = 3'b001;
        for (int k = 0; k <= 12; k++) begin
            tick();
            check("latency pressed", 32'(pressed[BTN_UP]), 32'(k >= 5 && k < 10));
            check("latency leds",    32'(leds),            32'(k >= 7 ? 1 : 0));
            if (k == 4) buttons = 3'b000;
        end
        repeat (6) tick();
        check_state("after press", 1, 1);
        $display("single press: leds=%0d sat=%0d", leds, leds_sat);

        // Pulses shorter than the debounce window must be ignored.
        for (int g = 0; g < 4; g++) begin
            buttons = 3'b001;
            for (int i = 0; i < 3; i++) begin
                tick();
                check("glitch pressed", 32'(pressed), 32'd0);
                check("glitch leds",    32'(leds),    32'd1);
            end
            buttons = 3'b000;
            for (int i = 0; i < 3; i++) begin
                tick();
                check("glitch pressed", 32'(pressed), 32'd0);
                check("glitch leds",    32'(leds),    32'd1);
            end
        end
        repeat (8) tick();
        check_state("after glitches", 1, 1);
        $display("glitch train: leds=%0d pressed=%b", leds, pressed);

        foreach (steps[i]) begin
            sb_t exp_rec;
            sb_q.push_back('{i, steps[i].exp_wrap, steps[i].exp_sat});
            press(steps[i].btn, steps[i].hold);
            exp_rec = sb_q.pop_front();
            check_state($sformatf("step %0d", exp_rec.idx), exp_rec.exp_wrap, exp_rec.exp_sat);
            $display("step %0d btn=%b hold=%0d: leds=%0d (exp %0d) sat=%0d (exp %0d)",
                     exp_rec.idx, steps[i].btn, steps[i].hold, leds, exp_rec.exp_wrap,
                     leds_sat, exp_rec.exp_sat);
        end

        // Bring both counters to 5, then reset in the middle of a debounce.
        press(3'b100, 5);
        for (int i = 0; i < 5; i++) press(3'b001, 5);
        check_state("pre-reset", 5, 5);
        buttons = 3'b001;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("reset mid leds",     32'(leds),     32'd0);
        check("reset mid sat leds", 32'(leds_sat), 32'd0);
        check("reset mid pressed",  32'(pressed),  32'd0);
        reset = 1'b0;
        for (int k = 0; k <= 11; k++) begin
            tick();
            check("post-reset pressed", 32'(pressed[BTN_UP]), 32'(k >= 5));
            check("post-reset leds",    32'(leds),            32'(k >= 7 ? 1 : 0));
            if (k == 6) buttons = 3'b000;
        end
        repeat (8) tick();
        check_state("post-reset final", 1, 1);
        $display("reset mid-debounce: leds=%0d sat=%0d", leds, leds_sat);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
